// File: rtl/pe_psum_requant.sv
// ============================================================================
// pe_psum_requant: accumulates 7-lane PE partial sums over multiple passes and
// requantizes to int8 (scale, round, shift, saturate). Option: PSUM_ACC_SAT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pe_psum_requant #(
  parameter int ROWS    = 7,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8,
  parameter int SCALE_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          psum_valid,
  output logic                          psum_ready,
  input  logic [ROWS-1:0][ACC_W-1:0]    psum_in,
  input  logic                          psum_first,
  input  logic                          psum_last,
  input  logic [SCALE_W-1:0]            scale,
  input  logic [4:0]                    shift,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ROWS-1:0][OUT_W-1:0]    act_out,
  output logic                          ovf
);

  localparam int PROD_W = ACC_W + SCALE_W + 1;
  localparam logic signed [PROD_W-1:0] RND_ONE = 1;

  logic [ROWS-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [ROWS-1:0][ACC_W-1:0] res_q, res_d;
  logic [ROWS-1:0][OUT_W-1:0] act_out_q, act_out_d;
  logic                       p_valid_q, p_valid_d;
  logic                       out_valid_q, out_valid_d;

  logic o_load, accept, p_to_o;
  logic [ROWS-1:0][ACC_W-1:0] sum;
  logic signed [PROD_W-1:0]   prod    [ROWS];
  logic signed [PROD_W-1:0]   rounded [ROWS];
  logic signed [PROD_W-1:0]   shifted [ROWS];
  logic [ROWS-1:0][OUT_W-1:0] quant;

  assign o_load     = !out_valid_q || out_ready;
  assign psum_ready = !p_valid_q || o_load;
  assign accept     = psum_valid && psum_ready;
  assign p_to_o     = p_valid_q && o_load;

`ifdef PSUM_ACC_SAT_EN
  logic [ROWS-1:0][ACC_W:0]   sum_wide;
  logic [ROWS-1:0][ACC_W-1:0] base;
  logic [ROWS-1:0]            lane_sat;
  logic                       ovf_q, ovf_d;

  // One guard bit catches signed overflow; a first beat adds onto zero and never saturates.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      base[i]     = psum_first ? '0 : acc_q[i];
      sum_wide[i] = {base[i][ACC_W-1], base[i]} + {psum_in[i][ACC_W-1], psum_in[i]};
      lane_sat[i] = sum_wide[i][ACC_W] != sum_wide[i][ACC_W-1];
      if (lane_sat[i]) begin
        sum[i] = sum_wide[i][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        sum[i] = sum_wide[i][ACC_W-1:0];
      end
    end
    ovf_d = ovf_q || (accept && (|lane_sat));
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      sum[i] = psum_first ? psum_in[i] : acc_q[i] + psum_in[i];
    end
  end

  assign ovf = 1'b0;
`endif

  // Scale is zero-extended so the full unsigned multiplier range is usable.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      prod[i] = PROD_W'($signed(res_q[i])) * PROD_W'($signed({1'b0, scale}));
      if (shift != 5'd0) rounded[i] = prod[i] + (RND_ONE << (shift - 5'd1));
      else               rounded[i] = prod[i];
      shifted[i] = rounded[i] >>> shift;
      if ((&shifted[i][PROD_W-1:OUT_W-1]) || !(|shifted[i][PROD_W-1:OUT_W-1])) begin
        quant[i] = shifted[i][OUT_W-1:0];
      end else begin
        quant[i] = shifted[i][PROD_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                        : {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end

  always_comb begin
    acc_d       = accept ? sum : acc_q;
    res_d       = (accept && psum_last) ? sum : res_q;
    p_valid_d   = p_valid_q;
    out_valid_d = out_valid_q;
    act_out_d   = act_out_q;
    if (p_to_o)           p_valid_d = 1'b0;
    if (accept && psum_last) p_valid_d = 1'b1;
    if (p_to_o) begin
      act_out_d   = quant;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      res_q       <= '0;
      act_out_q   <= '0;
      p_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      res_q       <= res_d;
      act_out_q   <= act_out_d;
      p_valid_q   <= p_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign act_out   = act_out_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_pe_psum_requant.sv
// ============================================================================
// tb_pe_psum_requant: table-driven and scoreboard bench for pe_psum_requant.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pe_psum_requant;
  localparam int ROWS = 7, ACC_W = 32, OUT_W = 8, SCALE_W = 16;

  typedef logic [ROWS-1:0][OUT_W-1:0] act_t;
  typedef logic [ROWS-1:0][ACC_W-1:0] ps_t;
  typedef struct {
    int a; int b; int scl; int sh; int ea; int eb;
  } vec_t;

  logic clk = 1'b0;
  logic rst, psum_valid, psum_ready, psum_first, psum_last;
  logic out_valid, out_ready, ovf;
  ps_t  psum_in;
  act_t act_out;
  logic [SCALE_W-1:0] scale;
  logic [4:0] shift;

  act_t exp_q[$];
  int n_cmp = 0, n_err = 0, n_out = 0, cyc = 0;

  always #5 clk = ~clk;

  pe_psum_requant #(.ROWS(ROWS), .ACC_W(ACC_W), .OUT_W(OUT_W), .SCALE_W(SCALE_W)) dut (
    .clk(clk), .rst(rst), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .psum_in(psum_in), .psum_first(psum_first), .psum_last(psum_last),
    .scale(scale), .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
    .act_out(act_out), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Even lanes carry a, odd lanes carry b.
  function automatic act_t mk(input int a, input int b);
    act_t v;
    for (int i = 0; i < ROWS; i++) v[i] = (i % 2 == 0) ? a[OUT_W-1:0] : b[OUT_W-1:0];
    return v;
  endfunction

  function automatic ps_t mkp(input int a, input int b);
    ps_t v;
    for (int i = 0; i < ROWS; i++) v[i] = (i % 2 == 0) ? a : b;
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: every output handshake pops and compares one expected vector.
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %0h expected none", act_out);
      end else begin
        chk("out_vec", act_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish expected done");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input logic first, input logic last,
                      input logic push, input act_t e);
    psum_in = mkp(a, b); psum_first = first; psum_last = last; psum_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (psum_ready) break;
    end
    if (!psum_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: psum_ready got 0 expected 1");
    end else begin
      @(posedge clk);
      if (push) exp_q.push_back(e);
      #1;
    end
    psum_valid = 1'b0;
  endtask

  vec_t tbl[9];
  int   c0, n0;

  initial begin
    tbl[0] = '{1000, 1000, 1, 4, 63, 63};
    tbl[1] = '{-6, 6, 1, 2, -1, 2};
    tbl[2] = '{127, -128, 1, 0, 127, -128};
    tbl[3] = '{128, -129, 1, 0, 127, -128};
    tbl[4] = '{-1, 1, 1, 1, 0, 1};
    tbl[5] = '{32'h7FFF_FFFF, 32'h8000_0000, 65535, 31, 127, -128};
    tbl[6] = '{5, -5, 0, 3, 0, 0};
    tbl[7] = '{300, -300, 100, 8, 117, -117};
    tbl[8] = '{3, -3, 1, 1, 2, -1};

    rst = 1'b1; psum_valid = 1'b0; psum_first = 1'b0; psum_last = 1'b0;
    psum_in = '0; out_ready = 1'b1; scale = 16'd1; shift = 5'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_act_out", act_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_psum_ready", psum_ready, 1);
    idle(1);

    // Latency: accept on edge N, out_valid high only after edge N+1.
    scale = 16'd1; shift = 5'd4;
    send(1000, 1000, 1'b1, 1'b1, 1'b1, mk(63, 63));
    @(negedge clk); chk("lat_edge_n", out_valid, 0);
    @(negedge clk); chk("lat_edge_n1", out_valid, 1);
    idle(3);

    for (int j = 0; j < 9; j++) begin
      scale = tbl[j].scl[SCALE_W-1:0];
      shift = tbl[j].sh[4:0];
      send(tbl[j].a, tbl[j].b, 1'b1, 1'b1, 1'b1, mk(tbl[j].ea, tbl[j].eb));
      idle(3);
    end

    // Multi-pass reductions.
    scale = 16'd3; shift = 5'd2;
    send(100, -200, 1'b1, 1'b0, 1'b0, '0);
    send(-30, -200, 1'b0, 1'b0, 1'b0, '0);
    send(50,  -200, 1'b0, 1'b1, 1'b1, mk(90, -128));
    idle(3);
    scale = 16'd1; shift = 5'd0;
    send(10, -200, 1'b1, 1'b0, 1'b0, '0);
    send(20, -200, 1'b0, 1'b0, 1'b0, '0);
    send(30, -200, 1'b0, 1'b1, 1'b1, mk(60, -128));
    idle(3);

    // Full throughput: four single-pass beats in four cycles.
    c0 = cyc;
    send(1, -1, 1'b1, 1'b1, 1'b1, mk(1, -1));
    send(2, -2, 1'b1, 1'b1, 1'b1, mk(2, -2));
    send(3, -3, 1'b1, 1'b1, 1'b1, mk(3, -3));
    send(4, -4, 1'b1, 1'b1, 1'b1, mk(4, -4));
    chk("throughput_cycles", cyc - c0, 4);
    idle(3);

    // Back-pressure: two results absorbed, third beat blocked, act_out held.
    out_ready = 1'b0;
    send(11, -11, 1'b1, 1'b1, 1'b1, mk(11, -11));
    send(22, -22, 1'b1, 1'b1, 1'b1, mk(22, -22));
    psum_in = mkp(33, -33); psum_first = 1'b1; psum_last = 1'b1; psum_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_psum_ready", psum_ready, 0);
      chk("bp_act_hold", act_out, mk(11, -11));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send(33, -33, 1'b1, 1'b1, 1'b1, mk(33, -33));
    idle(5);

    // Reset mid-reduction drops both the partial sum and an in-flight result.
    send(500, 500, 1'b1, 1'b0, 1'b0, '0);
    send(40, 40, 1'b0, 1'b1, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n0 = n_out;
    send(7, 7, 1'b0, 1'b1, 1'b1, mk(7, 7));
    idle(6);
    chk("rst_single_output", n_out - n0, 1);

    // Accumulator overflow.
    scale = 16'd1; shift = 5'd0;
`ifdef PSUM_ACC_SAT_EN
    send(32'h7FFF_0000, 32'h7FFF_0000, 1'b1, 1'b0, 1'b0, '0);
    send(32'h7FFF_0000, 32'h7FFF_0000, 1'b0, 1'b1, 1'b1, mk(127, 127));
    idle(3);
    chk("ovf_sticky", ovf, 1);
`else
    send(32'h7FFF_0000, 32'h7FFF_0000, 1'b1, 1'b0, 1'b0, '0);
    send(32'h7FFF_0000, 32'h7FFF_0000, 1'b0, 1'b1, 1'b1, mk(-128, -128));
    idle(3);
    chk("ovf_tied_low", ovf, 0);
`endif

    for (int k = 0; k < 50; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
